dmem_wb_bridge: RTL

Data-memory bridge between the core's request/response data port (`dmem_req`/`dmem_cmd`/`dmem_width`/`dmem_addr`/`dmem_wdata` → `dmem_rdata`/`dmem_resp`/`dmem_err`) and the Wishbone-classic data bus served by the Controller's second memory port.

- Produces byte-lane selects from `dmem_width`, replicates write data across lanes, and right-aligns read data.
- Rejects misaligned accesses without issuing a bus cycle.
- Buffers one request that arrives while a transaction is in flight.
- Registers every bus-side and core-side output, so the top level needs no extra ack/data pipeline stage.

---
 rtl/dmem_wb_bridge_if.sv | 33 +++
 rtl/dmem_wb_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wb_bridge_if.sv
// Signal bundle for dmem_wb_bridge: core data port, Wishbone-classic data bus and the overflow flag.
// master is the bridge's view; slave is the core + bus side.
interface dmem_wb_bridge_if;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr;
  logic [31:0] wb_data_out;
  logic [31:0] wb_data_in;
  logic        wb_ack;
  logic        overflow;

  modport master (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata, wb_data_in, wb_ack,
    output dmem_rdata, dmem_resp, dmem_err, wb_cyc, wb_stb, wb_we, wb_sel, wb_addr,
           wb_data_out, overflow
  );

  modport slave (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata, wb_data_in, wb_ack,
    input  dmem_rdata, dmem_resp, dmem_err, wb_cyc, wb_stb, wb_we, wb_sel, wb_addr,
           wb_data_out, overflow
  );
endinterface

// File: rtl/dmem_wb_bridge.sv
// Core data port to Wishbone-classic bridge with a one-entry request buffer and fully registered outputs.
// Optional bus timeout is enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transaction; launches a buffered or incoming request
// BUS    | wb_cyc/wb_stb high, waiting for wb_ack (or timeout)
// RESP   | dmem_resp pulse; launches the buffered request if one is held
module dmem_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  dmem_wb_bridge_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("dmem_wb_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;

  logic        buf_valid_q, buf_valid_d;
  logic        buf_cmd_q, buf_cmd_d;
  logic [1:0]  buf_width_q, buf_width_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_wdata_q, buf_wdata_d;

  logic [1:0]  xfer_width_q, xfer_width_d;
  logic [1:0]  xfer_ofs_q, xfer_ofs_d;

  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_we_q, wb_we_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [31:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_out_q, wb_data_out_d;

  logic [31:0] dmem_rdata_q, dmem_rdata_d;
  logic        dmem_resp_q, dmem_resp_d;
  logic        dmem_err_q, dmem_err_d;
  logic        overflow_q, overflow_d;

  logic        src_cmd;
  logic [1:0]  src_width;
  logic [31:0] src_addr;
  logic [31:0] src_wdata;
  logic        launch;
  logic        bus_done;
  logic        bus_fail;
  logic        tmo_hit;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] ofs);
    logic res;
    case (width)
      2'b00:   res = 1'b0;
      2'b01:   res = ofs[0];
      default: res = (ofs != 2'b00);
    endcase
    return res;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] width, input logic [1:0] ofs);
    logic [3:0] res;
    case (width)
      2'b00:   res = 4'b0001 << ofs;
      2'b01:   res = 4'b0011 << {ofs[1], 1'b0};
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] d);
    logic [31:0] res;
    case (width)
      2'b00:   res = {4{d[7:0]}};
      2'b01:   res = {2{d[15:0]}};
      default: res = d;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] align_rdata(input logic [31:0] d, input logic [1:0] width,
                                              input logic [1:0] ofs);
    logic [31:0] sh;
    logic [31:0] res;
    sh = d >> {ofs, 3'b000};
    case (width)
      2'b00:   res = {24'h0, sh[7:0]};
      2'b01:   res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // A held request always goes ahead of a newly arriving one.
  assign src_cmd   = buf_valid_q ? buf_cmd_q   : bus.dmem_cmd;
  assign src_width = buf_valid_q ? buf_width_q : bus.dmem_width;
  assign src_addr  = buf_valid_q ? buf_addr_q  : bus.dmem_addr;
  assign src_wdata = buf_valid_q ? buf_wdata_q : bus.dmem_wdata;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == S_BUS) && (tmo_cnt_q == '0);

  // Loaded on entry to BUS; terminal count 0 marks the last allowed BUS cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d == S_BUS && state_q != S_BUS) begin
      tmo_cnt_d = TMO_LOAD;
    end else if (state_q == S_BUS && tmo_cnt_q != '0) begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    buf_valid_d   = buf_valid_q;
    buf_cmd_d     = buf_cmd_q;
    buf_width_d   = buf_width_q;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    xfer_width_d  = xfer_width_q;
    xfer_ofs_d    = xfer_ofs_q;
    wb_cyc_d      = wb_cyc_q;
    wb_we_d       = wb_we_q;
    wb_sel_d      = wb_sel_q;
    wb_addr_d     = wb_addr_q;
    wb_data_out_d = wb_data_out_q;
    dmem_rdata_d  = 32'h0;
    dmem_resp_d   = 1'b0;
    dmem_err_d    = 1'b0;
    overflow_d    = overflow_q;
    launch        = 1'b0;
    bus_done      = 1'b0;
    bus_fail      = 1'b0;

    case (state_q)
      S_IDLE: launch = buf_valid_q | bus.dmem_req;
      S_BUS: begin
        if (bus.wb_ack) begin
          bus_done = 1'b1;
        end else if (tmo_hit) begin
          bus_done = 1'b1;
          bus_fail = 1'b1;
        end
      end
      S_RESP: begin
        if (buf_valid_q) begin
          launch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus_done) begin
      state_d       = S_RESP;
      wb_cyc_d      = 1'b0;
      wb_we_d       = 1'b0;
      wb_sel_d      = 4'h0;
      wb_addr_d     = 32'h0;
      wb_data_out_d = 32'h0;
      dmem_resp_d   = 1'b1;
      dmem_err_d    = bus_fail;
      if (!bus_fail && !wb_we_q) begin
        dmem_rdata_d = align_rdata(bus.wb_data_in, xfer_width_q, xfer_ofs_q);
      end
    end

    if (launch) begin
      if (is_misaligned(src_width, src_addr[1:0])) begin
        state_d     = S_RESP;
        dmem_resp_d = 1'b1;
        dmem_err_d  = 1'b1;
      end else begin
        state_d       = S_BUS;
        wb_cyc_d      = 1'b1;
        wb_we_d       = src_cmd;
        wb_sel_d      = lane_sel(src_width, src_addr[1:0]);
        wb_addr_d     = {src_addr[31:2], 2'b00};
        wb_data_out_d = lane_data(src_width, src_wdata);
        xfer_width_d  = src_width;
        xfer_ofs_d    = src_addr[1:0];
      end
    end

    if (launch && buf_valid_q) begin
      buf_valid_d = 1'b0;
    end

    // In IDLE the buffer is drained in the same cycle, so a new request may refill it.
    if (bus.dmem_req && !(launch && !buf_valid_q)) begin
      if (!buf_valid_q || state_q == S_IDLE) begin
        buf_valid_d = 1'b1;
        buf_cmd_d   = bus.dmem_cmd;
        buf_width_d = bus.dmem_width;
        buf_addr_d  = bus.dmem_addr;
        buf_wdata_d = bus.dmem_wdata;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      buf_valid_q   <= 1'b0;
      buf_cmd_q     <= 1'b0;
      buf_width_q   <= 2'b00;
      buf_addr_q    <= 32'h0;
      buf_wdata_q   <= 32'h0;
      xfer_width_q  <= 2'b00;
      xfer_ofs_q    <= 2'b00;
      wb_cyc_q      <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_sel_q      <= 4'h0;
      wb_addr_q     <= 32'h0;
      wb_data_out_q <= 32'h0;
      dmem_rdata_q  <= 32'h0;
      dmem_resp_q   <= 1'b0;
      dmem_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_valid_q   <= buf_valid_d;
      buf_cmd_q     <= buf_cmd_d;
      buf_width_q   <= buf_width_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      xfer_width_q  <= xfer_width_d;
      xfer_ofs_q    <= xfer_ofs_d;
      wb_cyc_q      <= wb_cyc_d;
      wb_we_q       <= wb_we_d;
      wb_sel_q      <= wb_sel_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_out_q <= wb_data_out_d;
      dmem_rdata_q  <= dmem_rdata_d;
      dmem_resp_q   <= dmem_resp_d;
      dmem_err_q    <= dmem_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.wb_cyc      = wb_cyc_q;
  assign bus.wb_stb      = wb_cyc_q;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_sel      = wb_sel_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data_out = wb_data_out_q;
  assign bus.dmem_rdata  = dmem_rdata_q;
  assign bus.dmem_resp   = dmem_resp_q;
  assign bus.dmem_err    = dmem_err_q;
  assign bus.overflow    = overflow_q;

endmodule
